// File: rtl/keyboard_scan_code_buffer.sv
// Purpose: buffers PS/2 scan-code bytes in a circular FIFO behind a two-register bus slave with a level interrupt.
// Latency: bus access completes with busWait=0 in the cycle after busEnable is sampled; interrupt follows push/pop by one cycle.
// Backpressure: none toward the keyboard; a byte arriving while full (and no same-cycle pop) is dropped and flags a sticky overflow.
module keyboard_scan_code_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        keyDataReady,
    input  logic [7:0]  keyData,
    input  logic        busEnable,
    input  logic        busWrite,
    input  logic        busAddress,
    input  logic [31:0] busDataIn,
    output logic [31:0] busDataOut,
    output logic        busWait,
    output logic        interrupt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    logic [0:0]            state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      countNext;
    logic                  overflow;
    logic                  overflowNext;
    logic                  irqEnable;
    logic                  irqEnableNext;
    logic                  accept;
    logic                  dataRead;
    logic                  statusWrite;
    logic                  doPop;
    logic                  doPush;
    logic                  doFlush;
    logic                  full;
    logic                  empty;
    logic [31:0]           readData;
    logic                  unusedBusBits;

    assign unusedBusBits = ^{busDataIn[31:4], busDataIn[0]};

    assign accept      = (state == IDLE) && busEnable;
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign dataRead    = accept && !busWrite && !busAddress;
    assign statusWrite = accept && busWrite && busAddress;
    assign doPop       = dataRead && !empty;
    assign doFlush     = statusWrite && busDataIn[3];
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign doPush      = keyDataReady && !doFlush && (!full || doPop);

    assign busWait = (state == IDLE);

    always_comb begin
        countNext = count;
        if (doFlush) begin
            countNext = '0;
        end else if (doPush && !doPop) begin
            countNext = count + CNT_W'(1);
        end else if (doPop && !doPush) begin
            countNext = count - CNT_W'(1);
        end
    end

    // Set beats clear when a dropped byte coincides with the clearing write.
    always_comb begin
        overflowNext = overflow;
        if (statusWrite && busDataIn[2]) begin
            overflowNext = 1'b0;
        end
        if (keyDataReady && !doFlush && full && !doPop) begin
            overflowNext = 1'b1;
        end
    end

    assign irqEnableNext = statusWrite ? busDataIn[1] : irqEnable;

    // Status reflects registers before any push landing in the same cycle.
    always_comb begin
        readData = 32'h0;
        if (busAddress) begin
            readData = {16'h0, 8'(count), 5'b0, overflow, irqEnable, !empty};
        end else if (!empty) begin
            readData = {24'h0, mem[rdPtr]};
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr] <= keyData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busDataOut <= 32'h0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            irqEnable  <= 1'b0;
            interrupt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (busEnable) begin
                        state      <= ACK;
                        busDataOut <= busWrite ? 32'h0 : readData;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busDataOut <= 32'h0;
                end
            endcase

            if (doFlush) begin
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (doPush) begin
                    wrPtr <= wrPtr + DEPTH_LOG2'(1);
                end
                if (doPop) begin
                    rdPtr <= rdPtr + DEPTH_LOG2'(1);
                end
            end

            count     <= countNext;
            overflow  <= overflowNext;
            irqEnable <= irqEnableNext;
            interrupt <= irqEnableNext && (countNext != '0);
        end
    end

endmodule
